// File: rtl/seg_scan_ctrl.sv
// Multiplexed hex-digit scanner: one digit per slot, guard-blanked anodes,
// frame-synchronous display update and optional leading-zero blanking.
//
// state   | meaning
// S_GUARD | first GUARD cycles of a slot, all anodes off
// S_DRIVE | rest of the slot, anode of the current digit on (unless blanked)
module seg_scan_ctrl #(
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV   = 50000,
    parameter int GUARD      = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [4*NUM_DIGITS-1:0]       value,
    input  logic                          load,
    input  logic                          blank_lz,
    output logic [3:0]                    digit,
    output logic [NUM_DIGITS-1:0]         an,
    output logic [$clog2(NUM_DIGITS)-1:0] idx,
    output logic                          frame_start
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [PW-1:0] PCNT_LAST = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
    localparam logic [PW-1:0] GUARD_END = PW'(GUARD);

    typedef enum logic {S_GUARD, S_DRIVE} state_t;

    state_t                  state, state_next;
    logic                    run;
    logic [PW-1:0]           pcnt, pcnt_next;
    logic [IW-1:0]           idx_next;
    logic [4*NUM_DIGITS-1:0] shadow, disp, disp_next;
    logic                    blank, blank_next, blank_sel;
    logic                    slot_start, frame_wrap;
    logic [NUM_DIGITS-1:0]   zero_above, an_sel, an_next;
    logic [3:0]              digit_next;

    // The first edge after reset opens slot 0 without advancing the prescaler.
    always_comb begin
        pcnt_next  = pcnt;
        idx_next   = idx;
        slot_start = !run || (pcnt == PCNT_LAST);
        if (run && pcnt == PCNT_LAST) begin
            pcnt_next = '0;
            idx_next  = (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else if (run) begin
            pcnt_next = pcnt + 1'b1;
        end
        frame_wrap = slot_start && (idx_next == '0);

        disp_next = disp;
        if (frame_wrap) begin
            disp_next = load ? value : shadow;
        end

        zero_above = '0;
        zero_above[NUM_DIGITS-1] = (disp_next[4*NUM_DIGITS-1 -: 4] == 4'h0);
        for (int k = NUM_DIGITS - 2; k >= 0; k--) begin
            zero_above[k] = (disp_next[4*k +: 4] == 4'h0) && zero_above[k+1];
        end

        digit_next = '0;
        an_sel     = '1;
        blank_sel  = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_next == IW'(k)) begin
                digit_next = disp_next[4*k +: 4];
                an_sel[k]  = 1'b0;
                blank_sel  = (k != 0) && zero_above[k];
            end
        end

        blank_next = blank;
        if (slot_start) begin
            blank_next = blank_lz && blank_sel;
        end

        state_next = state;
        case (state)
            S_GUARD: if (pcnt_next >= GUARD_END) state_next = S_DRIVE;
            S_DRIVE: if (slot_start) state_next = S_GUARD;
            default: state_next = S_GUARD;
        endcase

        an_next = (state_next == S_DRIVE && !blank_next) ? an_sel : '1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_GUARD;
            run         <= 1'b0;
            pcnt        <= '0;
            idx         <= '0;
            shadow      <= '0;
            disp        <= '0;
            blank       <= 1'b0;
            digit       <= '0;
            an          <= '1;
            frame_start <= 1'b0;
        end else begin
            state       <= state_next;
            run         <= 1'b1;
            pcnt        <= pcnt_next;
            idx         <= idx_next;
            if (load) begin
                shadow <= value;
            end
            disp        <= disp_next;
            blank       <= blank_next;
            digit       <= digit_next;
            an          <= an_next;
            frame_start <= frame_wrap;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl with 4 digits, 4-cycle slots, 1 guard cycle.
module tb_seg_scan_ctrl;
    localparam int N     = 4;
    localparam int S     = 4;
    localparam int G     = 1;
    localparam int FRAME = N * S;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        load     = 1'b0;
    logic        blank_lz = 1'b0;
    logic [15:0] value    = 16'h0;
    logic [3:0]  digit;
    logic [3:0]  an;
    logic [1:0]  idx;
    logic        frame_start;

    seg_scan_ctrl #(.NUM_DIGITS(N), .SCAN_DIV(S), .GUARD(G)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .value(value),
        .load(load),
        .blank_lz(blank_lz),
        .digit(digit),
        .an(an),
        .idx(idx),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    int errors   = 0;
    int checks   = 0;
    int n_edge   = 0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: position in the frame counts edges since release; the display
    // for a frame is the latest value loaded on or before that frame's first edge.
    int          m_t = 0, m_pos, m_pc, m_sl;
    logic [15:0] shadow_m = 16'h0, disp_m = 16'h0;
    bit          blank_m = 1'b0;
    logic [3:0]  e_digit = 4'h0, e_an = 4'hF;
    int          e_idx = 0;
    bit          e_fs = 1'b0;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_t = 0; shadow_m = 16'h0; disp_m = 16'h0; blank_m = 1'b0;
            e_digit = 4'h0; e_an = 4'hF; e_idx = 0; e_fs = 1'b0;
        end else begin
            m_t++;
            m_pos = m_t - 1;
            m_pc  = m_pos % S;
            m_sl  = (m_pos / S) % N;
            if (load) shadow_m = value;
            if (m_pos % FRAME == 0) disp_m = shadow_m;
            if (m_pc == 0)
                blank_m = blank_lz && (m_sl >= 1) && ((disp_m >> (4 * m_sl)) == 16'h0);
            e_digit = 4'((disp_m >> (4 * m_sl)) & 16'hF);
            e_an    = (m_pc < G || blank_m) ? 4'hF : 4'(~(1 << m_sl));
            e_idx   = m_sl;
            e_fs    = (m_pos % FRAME == 0);
        end
    end

    initial forever begin
        @(negedge clk);
        if (check_en) begin
            chk("m_digit", digit, e_digit);
            chk("m_an", an, e_an);
            chk("m_idx", idx, e_idx);
            chk("m_fs", frame_start, e_fs);
            chk("an_onehot", ($countones(~an) <= 1) ? 1 : 0, 1);
        end
    end

    task automatic tick();
        @(posedge clk);
        n_edge++;
        @(negedge clk);
    endtask

    task automatic run_to(input int e);
        while (n_edge < e) tick();
    endtask

    // Called just after a frame's first edge; walks all 16 cycles.
    task automatic check_frame(input string tag, input logic [15:0] digs, input logic [15:0] ans);
        for (int s = 0; s < N; s++) begin
            for (int pc = 0; pc < S; pc++) begin
                if (s != 0 || pc != 0) tick();
                chk({tag, "_digit"}, digit, digs[4*s +: 4]);
                chk({tag, "_an"}, an, (pc == 0) ? 4'hF : ans[4*s +: 4]);
            end
        end
    endtask

    initial begin
        int last;
        int waited;
        repeat (2) @(negedge clk);
        check_en = 1'b1;
        @(negedge clk);
        chk("rst_an", an, 4'hF);
        chk("rst_digit", digit, 0);
        chk("rst_idx", idx, 0);
        chk("rst_fs", frame_start, 0);

        rst_n = 1'b1; n_edge = 0;
        tick();
        chk("first_fs", frame_start, 1);
        chk("first_an", an, 4'hF);
        chk("first_idx", idx, 0);

        load = 1'b1; value = 16'h1A2F; tick(); load = 1'b0;
        run_to(17);
        check_frame("f1A2F", 16'h1A2F, 16'h7BDE);

        run_to(34); load = 1'b1; value = 16'h0000; tick(); load = 1'b0;
        run_to(39); load = 1'b1; value = 16'h1234; tick(); load = 1'b0;
        run_to(49);
        check_frame("f1234", 16'h1234, 16'h7BDE);

        load = 1'b1; value = 16'hBEEF; run_to(65); load = 1'b0;
        check_frame("fBEEF", 16'hBEEF, 16'h7BDE);

        blank_lz = 1'b1; load = 1'b1; value = 16'h00A0; run_to(81); load = 1'b0;
        check_frame("f00A0", 16'h00A0, 16'hFFDE);

        load = 1'b1; value = 16'h0000; run_to(97); load = 1'b0;
        run_to(98);  chk("zero_s0_an", an, 4'hE); chk("zero_s0_digit", digit, 0);
        run_to(102); chk("zero_s1_an", an, 4'hF);
        run_to(106); blank_lz = 1'b0;
        run_to(108); chk("blank_midslot_an", an, 4'hF);
        run_to(110); chk("unblank_s3_an", an, 4'h7); chk("unblank_s3_digit", digit, 0);
        load = 1'b1; value = 16'h9876; tick(); load = 1'b0;

        run_to(113);
        chk("f7_fs", frame_start, 1);
        for (int f = 0; f < 3; f++) begin
            last = n_edge;
            waited = 0;
            do begin
                tick();
                waited++;
            end while (frame_start !== 1'b1 && waited < 2 * FRAME);
            chk("fs_period", n_edge - last, FRAME);
        end

        run_to(162); load = 1'b1; value = 16'h5555; tick(); load = 1'b0;
        run_to(170);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_an", an, 4'hF);
        chk("async_idx", idx, 0);
        chk("async_digit", digit, 0);
        chk("async_fs", frame_start, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1; n_edge = 0;
        tick();
        chk("rel_fs", frame_start, 1);
        chk("rel_idx", idx, 0);
        chk("rel_digit", digit, 0);
        run_to(6);
        chk("rel_s1_an", an, 4'hD);
        chk("rel_s1_digit", digit, 0);
        run_to(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
